// File: rtl/cd_csr_wide_if.sv
// CSR bus bundle for cd_csr_wide: byte-addressed read/write strobes with
// lane enables and a waitrequest stall back to the master.
interface cd_csr_wide_if #(
    parameter int DW = 32
);
    localparam int NB = DW / 8;

    logic [6:0]    address;
    logic          read;
    logic          write;
    logic [NB-1:0] byteenable;
    logic [DW-1:0] writedata;
    logic [DW-1:0] readdata;
    logic          waitrequest;

    modport master (
        output address, read, write, byteenable, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, read, write, byteenable, writedata,
        output readdata, waitrequest
    );
endinterface

// File: rtl/cd_csr_wide.sv
// CSR block for the CD link controller: configuration registers, sticky
// interrupt flags, and byte-serialised RX/TX RAM data ports behind a wide bus.
//
// state   | meaning
// S_IDLE  | no burst; single-cycle config accesses, burst start in cycle 0
// S_RX    | RX data read burst, capturing one RAM byte per cycle
// S_TX    | TX data write burst, writing one enabled lane per cycle
module cd_csr_wide #(
    parameter logic [7:0] VERSION = 8'h10,
    parameter int         DW      = 32,
    parameter int         RAM_AW  = 8,
    parameter int         W1C     = 1,
    parameter int         DIV_LS  = 346,
    parameter int         DIV_HS  = 346
) (
    input  logic              clk,
    input  logic              reset_n,
    cd_csr_wide_if.slave      csr,
    output logic              irq,
    output logic              full_duplex,
    output logic              break_sync,
    output logic              arbitration,
    output logic              not_drop,
    output logic              user_crc,
    output logic              tx_invert,
    output logic              tx_push_pull,
    output logic [7:0]        idle_wait_len,
    output logic [1:0]        tx_pre_len,
    output logic [9:0]        tx_permit_len,
    output logic [9:0]        max_idle_len,
    output logic [7:0]        filter,
    output logic [7:0]        filter_m0,
    output logic [7:0]        filter_m1,
    output logic [15:0]       div_ls,
    output logic [15:0]       div_hs,
    output logic [RAM_AW-1:0] rx_ram_rd_addr,
    input  logic [7:0]        rx_ram_rd_byte,
    input  logic [7:0]        rx_ram_rd_len,
    input  logic              rx_ram_rd_err,
    input  logic              rx_error,
    input  logic              rx_ram_lost,
    input  logic              rx_break,
    input  logic              rx_pending,
    input  logic              bus_idle,
    output logic              rx_ram_rd_done,
    output logic              rx_clean_all,
    output logic              tx_ram_wr_en,
    output logic [RAM_AW-1:0] tx_ram_wr_addr,
    output logic [7:0]        tx_ram_wr_data,
    output logic              tx_ram_switch,
    output logic              tx_abort,
    output logic              has_break,
    input  logic              ack_break,
    input  logic              tx_pending,
    input  logic              cd,
    input  logic              tx_err
);

    localparam int         NB        = DW / 8;
    localparam logic [6:0] LANE_MASK = 7'(NB - 1);
    localparam logic [1:0] LAST      = 2'(NB - 1);

    typedef enum logic [1:0] {S_IDLE, S_RX, S_TX} state_t;

    state_t state_q, state_d;
    logic [1:0] cnt_q, cnt_d, lane;
    logic busy_wait, rx_adv, tx_we;

    logic [7:0]  setting_q, setting_d, idle_wait_q, idle_wait_d;
    logic [1:0]  pre_len_q, pre_len_d;
    logic [9:0]  permit_q, permit_d, max_idle_q, max_idle_d;
    logic [7:0]  filter_q, filter_d, fm0_q, fm0_d, fm1_q, fm1_d;
    logic [15:0] div_ls_q, div_ls_d, div_hs_q, div_hs_d;
    logic [7:0]  int_mask_q, int_mask_d;
    logic [1:0]  permit_sh_q, permit_sh_d, max_idle_sh_q, max_idle_sh_d;
    logic [7:0]  div_ls_sh_q, div_ls_sh_d, div_hs_sh_q, div_hs_sh_d;
    // sticky bit order: tx_err, cd, rx_error, rx_lost, rx_break
    logic [4:0]  sticky_q, sticky_d, sticky_set, sticky_clr;
    logic        has_break_q, has_break_d;
    logic        rx_clean_q, rx_clean_d, rx_done_q, rx_done_d;
    logic        tx_switch_q, tx_switch_d, tx_abort_q, tx_abort_d;
    logic [RAM_AW-1:0] rx_addr_q, rx_addr_d, tx_addr_q, tx_addr_d;
    logic [23:0] cap_q;

    logic [6:0]  base;
    logic [4:0]  word;
    logic [3:0]  be4;
    logic [31:0] wd32, rd32;
    logic [7:0]  int_flag;
    logic        acc_wr, acc_rd, w7_rd_hit;

    assign base   = csr.address & ~LANE_MASK;
    assign word   = csr.address[6:2];
    assign be4    = 4'(csr.byteenable);
    assign wd32   = 32'(csr.writedata);
    assign acc_wr = (state_q == S_IDLE) && csr.write;
    assign acc_rd = (state_q == S_IDLE) && csr.read && !csr.write;

    assign int_flag   = {sticky_q[4], sticky_q[3], ~tx_pending,
                         setting_q[3] ? rx_ram_rd_err : sticky_q[2],
                         sticky_q[1], sticky_q[0], rx_pending, bus_idle ^ setting_q[7]};
    assign sticky_set = {tx_err, cd, rx_error, rx_ram_lost, rx_break};
    assign irq        = |(int_flag & int_mask_q);

    always_comb begin : fsm_next
        state_d   = state_q;
        cnt_d     = cnt_q;
        lane      = 2'd0;
        busy_wait = 1'b0;
        rx_adv    = 1'b0;
        tx_we     = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = 2'd0;
                if (csr.write && word == 5'd9) begin
                    tx_we = be4[0];
                    if (NB > 1) begin
                        busy_wait = 1'b1;
                        state_d   = S_TX;
                        cnt_d     = 2'd1;
                    end
                end else if (csr.read && word == 5'd8) begin
                    rx_adv = 1'b1;
                    if (NB > 1) begin
                        busy_wait = 1'b1;
                        state_d   = S_RX;
                        cnt_d     = 2'd1;
                    end
                end
            end
            S_RX, S_TX: begin
                lane = cnt_q;
                if (state_q == S_RX) rx_adv = 1'b1;
                else                 tx_we  = be4[cnt_q];
                if (cnt_q == LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = 2'd0;
                end else begin
                    busy_wait = 1'b1;
                    cnt_d     = cnt_q + 2'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Shadows are updated first so a commit sees upper bytes from the same write.
    always_comb begin : cfg_next
        setting_d     = setting_q;
        idle_wait_d   = idle_wait_q;
        pre_len_d     = pre_len_q;
        permit_d      = permit_q;
        max_idle_d    = max_idle_q;
        filter_d      = filter_q;
        fm0_d         = fm0_q;
        fm1_d         = fm1_q;
        div_ls_d      = div_ls_q;
        div_hs_d      = div_hs_q;
        int_mask_d    = int_mask_q;
        permit_sh_d   = permit_sh_q;
        max_idle_sh_d = max_idle_sh_q;
        div_ls_sh_d   = div_ls_sh_q;
        div_hs_sh_d   = div_hs_sh_q;
        sticky_clr    = 5'd0;
        w7_rd_hit     = 1'b0;
        has_break_d   = has_break_q & ~ack_break;
        rx_clean_d    = 1'b0;
        rx_done_d     = 1'b0;
        tx_switch_d   = 1'b0;
        tx_abort_d    = 1'b0;
        if (acc_wr) begin
            for (int i = 0; i < NB; i++) begin
                if (be4[i]) begin
                    case (base | 7'(i))
                        7'h04: setting_d     = wd32[8*i +: 8];
                        7'h08: idle_wait_d   = wd32[8*i +: 8];
                        7'h09: pre_len_d     = wd32[8*i +: 2];
                        7'h0D: permit_sh_d   = wd32[8*i +: 2];
                        7'h0F: max_idle_sh_d = wd32[8*i +: 2];
                        7'h10: filter_d      = wd32[8*i +: 8];
                        7'h11: fm0_d         = wd32[8*i +: 8];
                        7'h12: fm1_d         = wd32[8*i +: 8];
                        7'h15: div_ls_sh_d   = wd32[8*i +: 8];
                        7'h17: div_hs_sh_d   = wd32[8*i +: 8];
                        7'h18: int_mask_d    = wd32[8*i +: 8];
                        7'h1C: if (W1C != 0)
                            sticky_clr = {wd32[8*i+7], wd32[8*i+6], wd32[8*i+4],
                                          wd32[8*i+3], wd32[8*i+2]};
                        7'h28: begin
                            rx_clean_d = wd32[8*i+4];
                            rx_done_d  = wd32[8*i+1];
                        end
                        7'h2C: begin
                            if (wd32[8*i+5]) has_break_d = 1'b1;
                            tx_abort_d  = wd32[8*i+4];
                            tx_switch_d = wd32[8*i+1];
                        end
                        default: ;
                    endcase
                end
            end
            for (int i = 0; i < NB; i++) begin
                if (be4[i]) begin
                    case (base | 7'(i))
                        7'h0C: permit_d   = {permit_sh_d, wd32[8*i +: 8]};
                        7'h0E: max_idle_d = {max_idle_sh_d, wd32[8*i +: 8]};
                        7'h14: div_ls_d   = {div_ls_sh_d, wd32[8*i +: 8]};
                        7'h16: div_hs_d   = {div_hs_sh_d, wd32[8*i +: 8]};
                        default: ;
                    endcase
                end
            end
        end
        if (acc_rd) begin
            for (int i = 0; i < NB; i++)
                if ((base | 7'(i)) == 7'h1C) w7_rd_hit = 1'b1;
        end
        if (W1C == 0 && w7_rd_hit) sticky_clr = 5'h1F;
        sticky_d = (sticky_q & ~sticky_clr) | sticky_set;
    end

    always_comb begin : addr_next
        rx_addr_d = rx_addr_q;
        tx_addr_d = tx_addr_q;
        if (acc_wr && word == 5'd10) rx_addr_d = '0;
        else if (rx_adv)             rx_addr_d = rx_addr_q + RAM_AW'(1);
        if (acc_wr && word == 5'd11) tx_addr_d = '0;
        else if (tx_we)              tx_addr_d = tx_addr_q + RAM_AW'(1);
    end

    always_comb begin : read_mux
        rd32 = 32'd0;
        for (int i = 0; i < NB; i++) begin
            case (base | 7'(i))
                7'h00: rd32[8*i +: 8] = VERSION;
                7'h04: rd32[8*i +: 8] = setting_q;
                7'h08: rd32[8*i +: 8] = idle_wait_q;
                7'h09: rd32[8*i +: 8] = {6'd0, pre_len_q};
                7'h0C: rd32[8*i +: 8] = permit_q[7:0];
                7'h0D: rd32[8*i +: 8] = {6'd0, permit_q[9:8]};
                7'h0E: rd32[8*i +: 8] = max_idle_q[7:0];
                7'h0F: rd32[8*i +: 8] = {6'd0, max_idle_q[9:8]};
                7'h10: rd32[8*i +: 8] = filter_q;
                7'h11: rd32[8*i +: 8] = fm0_q;
                7'h12: rd32[8*i +: 8] = fm1_q;
                7'h14: rd32[8*i +: 8] = div_ls_q[7:0];
                7'h15: rd32[8*i +: 8] = div_ls_q[15:8];
                7'h16: rd32[8*i +: 8] = div_hs_q[7:0];
                7'h17: rd32[8*i +: 8] = div_hs_q[15:8];
                7'h18: rd32[8*i +: 8] = int_mask_q;
                7'h1C: rd32[8*i +: 8] = int_flag;
                7'h1D: rd32[8*i +: 8] = rx_ram_rd_len;
                default: ;
            endcase
        end
        if (word == 5'd8) begin
            rd32 = {8'd0, cap_q};
            rd32[8*(NB-1) +: 8] = rx_ram_rd_byte;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= 2'd0;
            setting_q     <= 8'h10;
            idle_wait_q   <= 8'd10;
            pre_len_q     <= 2'd1;
            permit_q      <= 10'd20;
            max_idle_q    <= 10'd200;
            filter_q      <= 8'hFF;
            fm0_q         <= 8'hFF;
            fm1_q         <= 8'hFF;
            div_ls_q      <= 16'(DIV_LS);
            div_hs_q      <= 16'(DIV_HS);
            int_mask_q    <= 8'd0;
            permit_sh_q   <= 2'd0;
            max_idle_sh_q <= 2'd0;
            div_ls_sh_q   <= 8'd0;
            div_hs_sh_q   <= 8'd0;
            sticky_q      <= 5'd0;
            has_break_q   <= 1'b0;
            rx_clean_q    <= 1'b0;
            rx_done_q     <= 1'b0;
            tx_switch_q   <= 1'b0;
            tx_abort_q    <= 1'b0;
            rx_addr_q     <= '0;
            tx_addr_q     <= '0;
            cap_q         <= 24'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            setting_q     <= setting_d;
            idle_wait_q   <= idle_wait_d;
            pre_len_q     <= pre_len_d;
            permit_q      <= permit_d;
            max_idle_q    <= max_idle_d;
            filter_q      <= filter_d;
            fm0_q         <= fm0_d;
            fm1_q         <= fm1_d;
            div_ls_q      <= div_ls_d;
            div_hs_q      <= div_hs_d;
            int_mask_q    <= int_mask_d;
            permit_sh_q   <= permit_sh_d;
            max_idle_sh_q <= max_idle_sh_d;
            div_ls_sh_q   <= div_ls_sh_d;
            div_hs_sh_q   <= div_hs_sh_d;
            sticky_q      <= sticky_d;
            has_break_q   <= has_break_d;
            rx_clean_q    <= rx_clean_d;
            rx_done_q     <= rx_done_d;
            tx_switch_q   <= tx_switch_d;
            tx_abort_q    <= tx_abort_d;
            rx_addr_q     <= rx_addr_d;
            tx_addr_q     <= tx_addr_d;
            // the last lane is always served live, so it is never captured
            if (rx_adv && lane != LAST) cap_q[{lane, 3'b000} +: 8] <= rx_ram_rd_byte;
        end
    end

    // Gating with reset_n keeps a held bus from writing the RAM while in reset.
    assign tx_ram_wr_en    = tx_we & reset_n;
    assign tx_ram_wr_data  = wd32[{lane, 3'b000} +: 8];
    assign tx_ram_wr_addr  = tx_addr_q;
    assign rx_ram_rd_addr  = rx_addr_q;
    assign csr.waitrequest = busy_wait & reset_n;
    assign csr.readdata    = rd32[DW-1:0];

    assign full_duplex   = setting_q[6];
    assign break_sync    = setting_q[5];
    assign arbitration   = setting_q[4];
    assign not_drop      = setting_q[3];
    assign user_crc      = setting_q[2];
    assign tx_invert     = setting_q[1];
    assign tx_push_pull  = setting_q[0];
    assign idle_wait_len = idle_wait_q;
    assign tx_pre_len    = pre_len_q;
    assign tx_permit_len = permit_q;
    assign max_idle_len  = max_idle_q;
    assign filter        = filter_q;
    assign filter_m0     = fm0_q;
    assign filter_m1     = fm1_q;
    assign div_ls        = div_ls_q;
    assign div_hs        = div_hs_q;
    assign has_break     = has_break_q;
    assign rx_clean_all  = rx_clean_q;
    assign rx_ram_rd_done = rx_done_q;
    assign tx_ram_switch = tx_switch_q;
    assign tx_abort      = tx_abort_q;

endmodule

// File: tb/tb_cd_csr_wide.sv
// Directed bench for cd_csr_wide: a 32-bit write-1-to-clear instance and an
// 8-bit clear-on-read instance share clock, reset and status inputs.
module tb_cd_csr_wide;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] rx_ram_rd_len;
    logic rx_ram_rd_err, rx_error, rx_ram_lost, rx_break, rx_pending, bus_idle;
    logic ack_break, tx_pending, cd, tx_err;

    cd_csr_wide_if #(.DW(32)) bus32 ();
    cd_csr_wide_if #(.DW(8))  bus8 ();

    logic [7:0] rx_mem [256];
    logic [7:0] a_rx_byte;
    logic [7:0] b_rx_byte;
    assign b_rx_byte = 8'h00;

    logic a_irq, a_fd, a_bs, a_arb, a_nd, a_uc, a_ti, a_tpp;
    logic [7:0] a_iwl, a_flt, a_fm0, a_fm1;
    logic [1:0] a_tpl;
    logic [9:0] a_tpml, a_mil;
    logic [15:0] a_dls, a_dhs;
    logic [7:0] a_rx_addr, a_tx_addr, a_tx_data;
    logic a_rx_done, a_rx_clean, a_tx_we, a_tx_switch, a_tx_abort, a_has_break;

    logic b_irq, b_fd, b_bs, b_arb, b_nd, b_uc, b_ti, b_tpp;
    logic [7:0] b_iwl, b_flt, b_fm0, b_fm1;
    logic [1:0] b_tpl;
    logic [9:0] b_tpml, b_mil;
    logic [15:0] b_dls, b_dhs;
    logic [7:0] b_rx_addr, b_tx_addr, b_tx_data;
    logic b_rx_done, b_rx_clean, b_tx_we, b_tx_switch, b_tx_abort, b_has_break;

    assign a_rx_byte = rx_mem[a_rx_addr];

    cd_csr_wide #(.DW(32), .W1C(1)) u32 (
        .clk(clk), .reset_n(reset_n), .csr(bus32.slave), .irq(a_irq),
        .full_duplex(a_fd), .break_sync(a_bs), .arbitration(a_arb), .not_drop(a_nd),
        .user_crc(a_uc), .tx_invert(a_ti), .tx_push_pull(a_tpp),
        .idle_wait_len(a_iwl), .tx_pre_len(a_tpl), .tx_permit_len(a_tpml), .max_idle_len(a_mil),
        .filter(a_flt), .filter_m0(a_fm0), .filter_m1(a_fm1), .div_ls(a_dls), .div_hs(a_dhs),
        .rx_ram_rd_addr(a_rx_addr), .rx_ram_rd_byte(a_rx_byte), .rx_ram_rd_len(rx_ram_rd_len),
        .rx_ram_rd_err(rx_ram_rd_err), .rx_error(rx_error), .rx_ram_lost(rx_ram_lost),
        .rx_break(rx_break), .rx_pending(rx_pending), .bus_idle(bus_idle),
        .rx_ram_rd_done(a_rx_done), .rx_clean_all(a_rx_clean),
        .tx_ram_wr_en(a_tx_we), .tx_ram_wr_addr(a_tx_addr), .tx_ram_wr_data(a_tx_data),
        .tx_ram_switch(a_tx_switch), .tx_abort(a_tx_abort), .has_break(a_has_break),
        .ack_break(ack_break), .tx_pending(tx_pending), .cd(cd), .tx_err(tx_err)
    );

    cd_csr_wide #(.DW(8), .W1C(0)) u8 (
        .clk(clk), .reset_n(reset_n), .csr(bus8.slave), .irq(b_irq),
        .full_duplex(b_fd), .break_sync(b_bs), .arbitration(b_arb), .not_drop(b_nd),
        .user_crc(b_uc), .tx_invert(b_ti), .tx_push_pull(b_tpp),
        .idle_wait_len(b_iwl), .tx_pre_len(b_tpl), .tx_permit_len(b_tpml), .max_idle_len(b_mil),
        .filter(b_flt), .filter_m0(b_fm0), .filter_m1(b_fm1), .div_ls(b_dls), .div_hs(b_dhs),
        .rx_ram_rd_addr(b_rx_addr), .rx_ram_rd_byte(b_rx_byte), .rx_ram_rd_len(rx_ram_rd_len),
        .rx_ram_rd_err(rx_ram_rd_err), .rx_error(rx_error), .rx_ram_lost(rx_ram_lost),
        .rx_break(rx_break), .rx_pending(rx_pending), .bus_idle(bus_idle),
        .rx_ram_rd_done(b_rx_done), .rx_clean_all(b_rx_clean),
        .tx_ram_wr_en(b_tx_we), .tx_ram_wr_addr(b_tx_addr), .tx_ram_wr_data(b_tx_data),
        .tx_ram_switch(b_tx_switch), .tx_abort(b_tx_abort), .has_break(b_has_break),
        .ack_break(ack_break), .tx_pending(tx_pending), .cd(cd), .tx_err(tx_err)
    );

    // TX RAM write log for the 32-bit instance
    int wr_cnt = 0;
    logic [7:0] wr_addr_log [16];
    logic [7:0] wr_data_log [16];
    always @(posedge clk) begin
        if (a_tx_we) begin
            wr_addr_log[wr_cnt % 16] = a_tx_addr;
            wr_data_log[wr_cnt % 16] = a_tx_data;
            wr_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic acc32(input logic wr, input logic rd, input logic [6:0] a, input logic [3:0] be,
                         input logic [31:0] wd, input logic brk,
                         output logic [31:0] rdat, output int waits);
        bit done = 0;
        @(negedge clk);
        bus32.address = a; bus32.read = rd; bus32.write = wr;
        bus32.byteenable = be; bus32.writedata = wd; rx_break = brk;
        waits = 0; rdat = '0;
        for (int k = 0; k < 16 && !done; k++) begin
            #1;
            if (!bus32.waitrequest) begin
                rdat = bus32.readdata;
                done = 1;
            end else begin
                waits++;
            end
            @(posedge clk);
        end
        #1;
        bus32.read = 1'b0; bus32.write = 1'b0; rx_break = 1'b0;
        if (!done) check("acc32_timeout", 32'd1, 32'd0);
    endtask

    task automatic acc8(input logic wr, input logic rd, input logic [6:0] a, input logic [7:0] wd,
                        output logic [7:0] rdat);
        @(negedge clk);
        bus8.address = a; bus8.read = rd; bus8.write = wr;
        bus8.byteenable = 1'b1; bus8.writedata = wd;
        #1;
        rdat = bus8.readdata;
        check("acc8_nowait", {31'd0, bus8.waitrequest}, 32'd0);
        @(posedge clk);
        #1;
        bus8.read = 1'b0; bus8.write = 1'b0;
    endtask

    logic [31:0] r32;
    logic [7:0]  r8;
    int w;
    int base_cnt;

    initial begin
        for (int i = 0; i < 256; i++) rx_mem[i] = 8'h00;
        rx_mem[0] = 8'h11; rx_mem[1] = 8'h22; rx_mem[2] = 8'h33; rx_mem[3] = 8'h44;
        bus32.address = '0; bus32.read = 0; bus32.write = 0; bus32.byteenable = '0; bus32.writedata = '0;
        bus8.address = '0; bus8.read = 0; bus8.write = 0; bus8.byteenable = '0; bus8.writedata = '0;
        rx_ram_rd_len = 8'h5A; rx_ram_rd_err = 0; rx_error = 0; rx_ram_lost = 0; rx_break = 0;
        rx_pending = 0; bus_idle = 0; ack_break = 0; tx_pending = 1; cd = 0; tx_err = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;

        // reset state
        check("rst_setting", {25'd0, a_fd, a_bs, a_arb, a_nd, a_uc, a_ti, a_tpp}, 32'h10);
        check("rst_lens", {a_iwl, 4'd0, a_tpl, a_tpml, 2'd0, a_mil}, {8'd10, 4'd0, 2'd1, 10'd20, 2'd0, 10'd200});
        check("rst_filters", {8'd0, a_flt, a_fm0, a_fm1}, 32'h00FFFFFF);
        check("rst_divs", {a_dls, a_dhs}, {16'd346, 16'd346});
        check("rst_misc", {24'd0, a_irq, bus32.waitrequest, a_has_break, a_tx_we,
                           a_rx_clean, a_rx_done, a_tx_switch, a_tx_abort}, 32'd0);
        check("rst_addrs", {16'd0, a_rx_addr, a_tx_addr}, 32'd0);

        // 8-bit lanes: upper byte of div_ls sits in the shadow until byte 0 commits
        acc8(1, 0, 7'h15, 8'h01, r8);
        check("div_ls_shadow_only", {16'd0, b_dls}, 32'h015A);
        acc8(1, 0, 7'h14, 8'h80, r8);
        check("div_ls_commit", {16'd0, b_dls}, 32'h0180);
        check("div_hs_untouched", {16'd0, b_dhs}, 32'h015A);

        // clear-on-read of the cd sticky flag
        @(negedge clk); cd = 1'b1;
        @(negedge clk); cd = 1'b0;
        acc8(0, 1, 7'h1C, 8'h00, r8);
        check("cor_first_read", {24'd0, r8}, 32'h40);
        acc8(0, 1, 7'h1C, 8'h00, r8);
        check("cor_second_read", {24'd0, r8}, 32'h00);

        // 32-bit readback of reset config words and the version
        acc32(0, 1, 7'h00, 4'hF, 32'd0, 0, r32, w);
        check("version", r32, 32'h00000010);
        acc32(0, 1, 7'h08, 4'hF, 32'd0, 0, r32, w);
        check("w2_read", r32, 32'h0000010A);
        acc32(0, 1, 7'h0C, 4'hF, 32'd0, 0, r32, w);
        check("w3_read", r32, 32'h00C80014);

        // RX burst read
        acc32(0, 1, 7'h20, 4'hF, 32'd0, 0, r32, w);
        check("rx_data", r32, 32'h44332211);
        check("rx_waits", w, 32'd3);
        check("rx_addr_after", {24'd0, a_rx_addr}, 32'd4);

        // TX burst write with a disabled lane
        base_cnt = wr_cnt;
        acc32(1, 0, 7'h24, 4'b1011, 32'hA1B2C3D4, 0, r32, w);
        check("tx_waits", w, 32'd3);
        check("tx_nwrites", wr_cnt - base_cnt, 32'd3);
        check("tx_w0", {16'd0, wr_addr_log[base_cnt % 16], wr_data_log[base_cnt % 16]}, 32'h00D4);
        check("tx_w1", {16'd0, wr_addr_log[(base_cnt+1) % 16], wr_data_log[(base_cnt+1) % 16]}, 32'h01C3);
        check("tx_w2", {16'd0, wr_addr_log[(base_cnt+2) % 16], wr_data_log[(base_cnt+2) % 16]}, 32'h02A1);
        check("tx_addr_after", {24'd0, a_tx_addr}, 32'd3);

        // upper-lane write of div_hs overrides the shadow in the same commit
        acc32(1, 0, 7'h14, 4'b1100, 32'h12340000, 0, r32, w);
        check("div_wide_commit", {a_dls, a_dhs}, 32'h015A1234);

        // write-1-to-clear and set-wins
        @(negedge clk); rx_break = 1'b1;
        @(negedge clk); rx_break = 1'b0;
        acc32(1, 0, 7'h18, 4'h1, 32'h04, 0, r32, w);
        check("irq_set", {31'd0, a_irq}, 32'd1);
        acc32(1, 0, 7'h1C, 4'h1, 32'h04, 0, r32, w);
        check("irq_cleared", {31'd0, a_irq}, 32'd0);
        acc32(1, 0, 7'h1C, 4'h1, 32'h04, 1, r32, w);
        check("irq_set_wins", {31'd0, a_irq}, 32'd1);
        acc32(0, 1, 7'h1C, 4'hF, 32'd0, 0, r32, w);
        check("w7_read", r32, 32'h00005A44);

        // RX_CTRL
        acc32(1, 0, 7'h28, 4'h1, 32'h12, 0, r32, w);
        check("rx_ctrl_pulses", {16'd0, a_rx_addr, 6'd0, a_rx_clean, a_rx_done}, 32'h0003);
        @(posedge clk); #1;
        check("rx_ctrl_pulse_end", {30'd0, a_rx_clean, a_rx_done}, 32'd0);

        // TX_CTRL: break request, switch pulse, address reset
        acc32(1, 0, 7'h2C, 4'h1, 32'h22, 0, r32, w);
        check("tx_ctrl", {16'd0, a_tx_addr, 5'd0, a_has_break, a_tx_switch, a_tx_abort}, 32'h0006);
        @(negedge clk); ack_break = 1'b1;
        @(negedge clk); ack_break = 1'b0;
        #1;
        check("ack_break", {30'd0, a_has_break, a_tx_switch}, 32'd0);

        // unmapped bits and read-only words
        acc32(1, 0, 7'h18, 4'hF, 32'hFFFFFFFF, 0, r32, w);
        acc32(0, 1, 7'h18, 4'hF, 32'd0, 0, r32, w);
        check("w6_unmapped", r32, 32'h000000FF);
        acc32(1, 0, 7'h00, 4'hF, 32'hFFFFFFFF, 0, r32, w);
        acc32(0, 1, 7'h00, 4'hF, 32'd0, 0, r32, w);
        check("w0_readonly", r32, 32'h00000010);

        // reset in cycle 1 of a TX burst
        base_cnt = wr_cnt;
        @(negedge clk);
        bus32.address = 7'h24; bus32.write = 1'b1; bus32.byteenable = 4'hF; bus32.writedata = 32'h55667788;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        bus32.write = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_burst_writes", wr_cnt - base_cnt, 32'd1);
        check("rst_burst_state", {16'd0, a_tx_addr, 7'd0, bus32.waitrequest}, 32'd0);
        @(negedge clk); reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_idle", {30'd0, bus32.waitrequest, a_tx_we}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cd_csr_wide.md
CD_CSR_WIDE -- requirements
Module: cd_csr_wide

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- VERSION, 8'h10, value returned by the VERSION register.
- DW, 32, CSR data width in bits; legal values are 8, 16 and 32; NB = DW/8.
- RAM_AW, 8, address width of the rx and tx RAMs.
- W1C, 1, interrupt-flag clearing mode: 1 = write-1-to-clear, 0 = clear-on-read.
- DIV_LS, 346, reset value of div_ls.
- DIV_HS, 346, reset value of div_hs.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock.
- reset_n, in, 1, reset, asynchronous, active-low.
- csr_address, in, 7, byte address.
- csr_read, in, 1, read strobe.
- csr_write, in, 1, write strobe.
- csr_byteenable, in, NB, byte-lane enables.
- csr_writedata, in, DW, write data.
- csr_readdata, out, DW, read data, combinational.
- csr_waitrequest, out, 1, stall; the bus holds address, strobes and data while it is high.
- irq, out, 1, interrupt.
- Configuration outputs (all out): full_duplex, break_sync, arbitration, not_drop, user_crc, tx_invert, tx_push_pull (1 each); idle_wait_len 8; tx_pre_len 2; tx_permit_len 10; max_idle_len 10; filter, filter_m0, filter_m1 8 each; div_ls, div_hs 16 each.
- RX side: rx_ram_rd_addr out RAM_AW; rx_ram_rd_byte in 8, combinational read of rx_ram_rd_addr; rx_ram_rd_len in 8; rx_ram_rd_err, rx_error, rx_ram_lost, rx_break, rx_pending, bus_idle in 1 each; rx_ram_rd_done, rx_clean_all out 1 each, single-cycle pulses.
- TX side: tx_ram_wr_en out 1; tx_ram_wr_addr out RAM_AW; tx_ram_wr_data out 8; tx_ram_switch, tx_abort out 1 each, pulses; has_break out 1; ack_break, tx_pending, cd, tx_err in 1 each.

Function
REQ-003 The register map SHALL consist of 32-bit words; the byte at address 4*W+L is lane L of word W.
- W0 VERSION, read-only, [7:0].
- W1 SETTING[7:0], bits idle_invert, full_duplex, break_sync, arbitration, not_drop, user_crc, tx_invert, tx_push_pull (MSB to LSB).
- W2 idle_wait_len[7:0], tx_pre_len[9:8].
- W3 tx_permit_len[9:0], max_idle_len[25:16].
- W4 filter[7:0], filter_m0[15:8], filter_m1[23:16].
- W5 div_ls[15:0], div_hs[31:16].
- W6 int_mask[7:0].
- W7 int_flag[7:0] plus rx_ram_rd_len[15:8], read-only.
- W8 RX data.
- W9 TX data.
- W10 RX_CTRL.
- W11 TX_CTRL.
- Unmapped bits SHALL read 0 and ignore writes.
REQ-004 A configuration access SHALL touch only the enabled lanes, at lane offsets (csr_address & ~(NB-1)) + i.
REQ-005 A multi-byte field SHALL update atomically:
- Writes to its upper bytes go to a per-field shadow.
- The write that includes its byte 0 commits {shadow, new bytes} in one cycle; lanes of that same write override the shadow.
- Any access to a different field SHALL NOT clear the shadow.
REQ-006 int_flag SHALL be {tx_err_f, cd_f, ~tx_pending, not_drop ? rx_ram_rd_err : rx_err_f, rx_lost_f, rx_break_f, rx_pending, bus_idle ^ idle_invert}. Sticky bits (_f) SHALL be set by their input pulse.
REQ-007 With W1C=1, writing 1 to a sticky bit SHALL clear it. With W1C=0, any read of W7 lane 0 SHALL clear all sticky bits.
REQ-008 If a set and a clear of a sticky bit occur in the same cycle, set SHALL win.
REQ-009 irq SHALL equal |(int_flag & int_mask), combinationally.
REQ-010 An RX data read SHALL take NB cycles; csr_waitrequest is high for cycles 0..NB-2.
- In cycle i the block captures rx_ram_rd_byte into lane i and increments rx_ram_rd_addr.
- In cycle NB-1 readdata lane NB-1 is the live byte and the other lanes are the captured bytes (little-endian).
- NB=1 SHALL have zero wait.
REQ-011 A TX data write SHALL take NB cycles; csr_waitrequest is high for cycles 0..NB-2.
- In cycle i, if byteenable[i], the block asserts tx_ram_wr_en with tx_ram_wr_data = lane i and then increments tx_ram_wr_addr.
- A disabled lane SHALL produce no write and no increment.
REQ-012 RAM addresses SHALL wrap modulo 2^RAM_AW without side effects.
REQ-013 A write to RX_CTRL SHALL reset rx_ram_rd_addr to 0, pulse rx_clean_all when bit4 is set, and pulse rx_ram_rd_done when bit1 is set.
REQ-014 A write to TX_CTRL SHALL reset tx_ram_wr_addr to 0, set has_break when bit5 is set, pulse tx_abort when bit4 is set, and pulse tx_ram_switch when bit1 is set.
REQ-015 has_break SHALL clear on ack_break. If ack_break and a has_break set occur in the same cycle, set SHALL win.
REQ-016 A read or write strobe arriving while a burst is in progress SHALL be treated as the held bus transaction, not as a new access.
REQ-017 If csr_read and csr_write are both asserted, the write SHALL be performed and the read data is undefined.

Reset
REQ-018 On reset the block SHALL apply these values:
- SETTING = 8'h10 (arbitration=1).
- idle_wait_len=10, tx_permit_len=20, max_idle_len=200, tx_pre_len=1.
- filter, filter_m0, filter_m1 = 8'hFF.
- div_ls=DIV_LS, div_hs=DIV_HS.
- int_mask=0; all sticky flags, shadows and RAM addresses = 0.
- All pulse outputs, has_break, tx_ram_wr_en and csr_waitrequest = 0.
REQ-019 Reset asserted during a burst SHALL abort the burst immediately with no further RAM writes; after release the block SHALL be idle.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- DW=32: rx bytes 11,22,33,44 at address 0 -> after one W8 read, readdata = 32'h44332211, 3 wait cycles, rx_ram_rd_addr=4.
- DW=32: W9 write 32'hA1B2C3D4 with byteenable 4'b1011 -> 3 RAM writes (D4, C3, A1) at addresses 0, 1, 2.
- DW=8: write 8'h01 to 0x15, then 8'h80 to 0x14 -> div_ls=16'h0180, committed in one cycle; div_hs unchanged.
- W1C=1: rx_break pulse, int_mask=8'h04 -> irq=1; write W7=8'h04 -> irq=0. A same-cycle clear and new rx_break -> flag stays 1.
- W1C=0: cd pulse, then read W7 -> returns bit6=1; the next read returns bit6=0.
- Reset mid TX burst (DW=32, after cycle 1) -> exactly one RAM write observed, tx_ram_wr_addr=0, csr_waitrequest=0.
